syn_pcm_buffer: RTL
===================

Name: syn_pcm_buffer

Overview:
- Ping-pong PCM sample buffer that acts as the responder on the left/right channel memory interfaces (DATA_W=32, ADDR_W=7) driven by syn_fgyrus.
- Sits between the audio capture path and syn_fgyrus.
  - Captures stereo samples into one bank per channel.
  - When a bank holds 128 samples, pulses pcm_rdy and hands that bank to the reader.
  - Capture continues into the other bank.

Parameters:
P_DATA_W, 32, sample/memory data width
P_ADDR_W, 7, address width; bank depth = 2**P_ADDR_W = 128
P_MEM_RD_DEL, 2, read latency in cycles from rden to rd_valid/rdata

Ports:
clk_ir  in  1  system clock
rst_sync_l  in  1  reset, synchronous, active-low
sample_valid_ih  in  1  one stereo sample pair presented this cycle
lchnnl_sample_id  in  P_DATA_W  left sample
rchnnl_sample_id  in  P_DATA_W  right sample
pcm_rdy_oh  out  1  one-cycle pulse: a full bank was handed to the reader
lchnnl_rden_ih  in  1  left read enable
lchnnl_wren_ih  in  1  left write enable (reader write-back)
lchnnl_addr_id  in  P_ADDR_W  left address
lchnnl_wdata_id  in  P_DATA_W  left write data
lchnnl_rdata_od  out  P_DATA_W  left read data
lchnnl_rd_valid_od  out  1  left read data valid
rchnnl_* (rden/wren/addr/wdata/rdata/rd_valid)  same as lchnnl_*, right channel
wr_bank_od  out  1  bank currently being captured; reader bank = ~wr_bank_od
ovrflw_oh  out  1  sticky: bank handed over before reader touched previous one

Behaviour:
- All state updates on posedge clk_ir; rst_sync_l=0 sampled at a clock edge resets.
- Reset values:
  - wr_ptr=0, wr_bank_od=0, pcm_rdy_oh=0.
  - rd_valid pipelines=0, rdata=0, ovrflw_oh=0, rd_touched=1.
  - RAM contents are not cleared.
- Storage: per channel, 2 banks x 128 x P_DATA_W; physical address = {bank, addr}.
- Capture:
  - On sample_valid_ih=1, write L/R samples to {wr_bank, wr_ptr}, then wr_ptr++.
  - When wr_ptr==127 and sample_valid_ih=1, the write completes the bank. Next cycle:
    - wr_ptr=0 (wrap);
    - wr_bank toggles;
    - pcm_rdy_oh=1 for exactly one cycle.
  - Back-to-back sample_valid_ih every cycle is supported; no sample is dropped across the flip.
- Overflow: rd_touched clears on the pcm_rdy_oh cycle and sets on any rden/wren from either channel.
  - If a bank completes while rd_touched=0, ovrflw_oh sets (sticky until reset).
  - The flip still occurs; the oldest unread bank is overwritten.
- Read port (per channel, independent):
  - rden sampled with addr and current reader bank (~wr_bank).
  - rdata/rd_valid appear exactly P_MEM_RD_DEL cycles later, as a 1-cycle rd_valid per rden.
  - Fully pipelined: one read per cycle.
  - Bank is latched at rden time, so reads in flight across a flip return the old bank's data.
  - Reads issued in the pcm_rdy_oh cycle target the new reader bank.
  - rdata holds its last value when rd_valid=0.
- Write port (reader write-back):
  - wren writes wdata to {~wr_bank, addr}, allowing in-place results.
  - rden and wren in the same cycle at the same address: read returns the old data (read-before-write).
- The reader never accesses the capture bank; capture and reader accesses never collide.
- Before the first pcm_rdy_oh, reader-bank reads return undefined RAM contents.
- Reset asserted mid-capture or mid-read:
  - partial bank is discarded (wr_ptr=0, bank 0);
  - in-flight reads are dropped (no rd_valid after reset).

Test Plan:
- Reset then 128 consecutive samples, L=i, R=0x1000+i:
  - pcm_rdy_oh pulses once, the cycle after the 128th write;
  - wr_bank_od=1.
  - Read addr 0..127 back-to-back on both channels: rd_valid 2 cycles after each rden; L data 0..127, R 0x1000..0x107F.
- Samples with gaps (valid every 3rd cycle) for 256 samples: two pcm_rdy_oh pulses 128 samples apart; wr_bank_od returns to 0.
- Reads at addr 5 issued 1 cycle before a flip and in the pcm_rdy_oh cycle: first returns old-bank data, second returns new-bank data.
- Write-back: wren addr 10 data 0xDEADBEEF with rden addr 10 same cycle:
  - read returns the old value;
  - a later read returns 0xDEADBEEF.
  - The capture bank is unaffected.
- 256 samples with no reads between: ovrflw_oh=1 after the second flip; it stays 1 through further reads until reset.
- Reset asserted after 50 samples and 1 cycle after a rden:
  - no rd_valid emerges;
  - 128 further samples are needed to produce pcm_rdy_oh.

Source files
------------

// File: rtl/syn_pcm_buffer.sv
// Ping-pong stereo PCM buffer: captures 128-sample banks per channel and
// serves the completed bank to a reader over two pipelined memory ports.
module syn_pcm_buffer #(
  parameter int P_DATA_W     = 32,
  parameter int P_ADDR_W     = 7,
  parameter int P_MEM_RD_DEL = 2
) (
  input  logic                clk_ir,
  input  logic                rst_sync_l,

  input  logic                sample_valid_ih,
  input  logic [P_DATA_W-1:0] lchnnl_sample_id,
  input  logic [P_DATA_W-1:0] rchnnl_sample_id,
  output logic                pcm_rdy_oh,

  input  logic                lchnnl_rden_ih,
  input  logic                lchnnl_wren_ih,
  input  logic [P_ADDR_W-1:0] lchnnl_addr_id,
  input  logic [P_DATA_W-1:0] lchnnl_wdata_id,
  output logic [P_DATA_W-1:0] lchnnl_rdata_od,
  output logic                lchnnl_rd_valid_od,

  input  logic                rchnnl_rden_ih,
  input  logic                rchnnl_wren_ih,
  input  logic [P_ADDR_W-1:0] rchnnl_addr_id,
  input  logic [P_DATA_W-1:0] rchnnl_wdata_id,
  output logic [P_DATA_W-1:0] rchnnl_rdata_od,
  output logic                rchnnl_rd_valid_od,

  output logic                wr_bank_od,
  output logic                ovrflw_oh
);

  localparam int DEPTH = 1 << P_ADDR_W;

  logic [P_ADDR_W-1:0] wr_ptr;
  logic                wr_bank;
  logic                rd_bank;
  logic                pcm_rdy;
  logic                ovrflw;
  logic                rd_touched;
  logic                bank_done;
  logic                rd_access;

  // Channel-indexed views of the two reader ports: index 0 = left, 1 = right.
  logic [1:0]                rden;
  logic [1:0]                wren;
  logic [1:0]                rd_valid;
  logic [1:0][P_ADDR_W-1:0]  addr;
  logic [1:0][P_DATA_W-1:0]  wdata;
  logic [1:0][P_DATA_W-1:0]  cap_data;
  logic [1:0][P_DATA_W-1:0]  rdata;

  assign rden     = {rchnnl_rden_ih, lchnnl_rden_ih};
  assign wren     = {rchnnl_wren_ih, lchnnl_wren_ih};
  assign addr     = {rchnnl_addr_id, lchnnl_addr_id};
  assign wdata    = {rchnnl_wdata_id, lchnnl_wdata_id};
  assign cap_data = {rchnnl_sample_id, lchnnl_sample_id};

  assign rd_bank   = ~wr_bank;
  assign bank_done = sample_valid_ih & (&wr_ptr);
  assign rd_access = |{rden, wren};

  // An access in the completing cycle still counts against the bank being
  // handed away; the flag then restarts for the freshly handed-over bank.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      wr_ptr     <= '0;
      wr_bank    <= 1'b0;
      pcm_rdy    <= 1'b0;
      ovrflw     <= 1'b0;
      rd_touched <= 1'b1;
    end else begin
      pcm_rdy <= bank_done;
      if (sample_valid_ih) wr_ptr <= wr_ptr + 1'b1;
      if (bank_done) begin
        wr_bank    <= ~wr_bank;
        rd_touched <= 1'b0;
        if (!rd_touched && !rd_access) ovrflw <= 1'b1;
      end else if (rd_access) begin
        rd_touched <= 1'b1;
      end
    end
  end

  generate
    for (genvar c = 0; c < 2; c++) begin : g_chnnl
      logic [P_DATA_W-1:0]     mem [2*DEPTH];
      logic [P_MEM_RD_DEL-1:0] vld;
      logic [P_DATA_W-1:0]     dat [P_MEM_RD_DEL];

      // NOTE: the RAM has no reset so it maps onto block memory; contents
      // survive rst_sync_l and are undefined until first written.
      always_ff @(posedge clk_ir) begin
        if (sample_valid_ih) mem[{wr_bank, wr_ptr}]  <= cap_data[c];
        if (wren[c])         mem[{rd_bank, addr[c]}] <= wdata[c];
      end

      // Stage 0 samples the RAM before this edge's write-back lands, which
      // gives read-before-write; the bank is fixed at rden time.
      always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
          vld <= '0;
          for (int k = 0; k < P_MEM_RD_DEL; k++) dat[k] <= '0;
        end else begin
          vld[0] <= rden[c];
          if (rden[c]) dat[0] <= mem[{rd_bank, addr[c]}];
          for (int k = 1; k < P_MEM_RD_DEL; k++) begin
            vld[k] <= vld[k-1];
            if (vld[k-1]) dat[k] <= dat[k-1];
          end
        end
      end

      assign rdata[c]    = dat[P_MEM_RD_DEL-1];
      assign rd_valid[c] = vld[P_MEM_RD_DEL-1];
    end
  endgenerate

  assign pcm_rdy_oh         = pcm_rdy;
  assign wr_bank_od         = wr_bank;
  assign ovrflw_oh          = ovrflw;
  assign lchnnl_rdata_od    = rdata[0];
  assign rchnnl_rdata_od    = rdata[1];
  assign lchnnl_rd_valid_od = rd_valid[0];
  assign rchnnl_rd_valid_od = rd_valid[1];

endmodule
